// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipeline-register stage: state encoding,
// ID->EX payload layout and its NOP encoding.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [4:0]  REG_NOP       = 5'd0;
  localparam logic [31:0] ID_NOP        = 32'd0;
  localparam logic [1:0]  TYPE_NOP      = 2'd0;
  localparam logic [31:0] ZERO32        = 32'd0;

  typedef struct packed {
    logic        rd_e;
    logic [4:0]  rd_idx;
    logic [31:0] inst_idx;
    logic [1:0]  inst_type;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

  localparam id_ex_t ID_EX_NOP = '{
    rd_e:      WRITE_DISABLE,
    rd_idx:    REG_NOP,
    inst_idx:  ID_NOP,
    inst_type: TYPE_NOP,
    rs1_data:  ZERO32,
    rs2_data:  ZERO32
  };

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    case (s)
      ST_HALF: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_buf.sv
// Skid entry for pipe_stage: catches the beat accepted while the head stalls
// and feeds it back to the main register when the head drains.
module pipe_skid_buf
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W  = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear,
  input  logic              load_skid,
  input  logic              pop_skid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] main_next
);

  logic [DATA_W-1:0] skid_q;

  // The entry returns to NOP whenever it is not holding a live beat.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      skid_q <= NOP_VAL;
    end else if (clear || pop_skid) begin
      skid_q <= NOP_VAL;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign main_next = pop_skid ? skid_q : in_data;

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline register (ID->EX and friends) with optional
// two-entry skid buffer, flush and NOP fill when empty.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | no live beat, out_data = NOP_VAL
// ST_HALF  | main register live
// ST_FULL  | main and skid live, upstream blocked (SKID=1 only)
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W  = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(ID_EX_NOP),
  parameter int unsigned       SKID    = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_next;
  logic              ready_q;
  logic              push, pop;
  logic              load_main, load_skid, pop_skid;

  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : NOP_VAL;
  assign occupancy = occ_of(state_q);

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ready_q & (state_q != ST_FULL);

      pipe_skid_buf #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP_VAL)
      ) u_skid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (flush),
        .load_skid (load_skid),
        .pop_skid  (pop_skid),
        .in_data   (in_data),
        .main_next (main_next)
      );
    end else begin : g_noskid
      assign in_ready  = ready_q & (~out_valid | out_ready);
      assign main_next = in_data;
    end
  endgenerate

  // ready_q keeps the first edge after reset from accepting a stale beat.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      main_q <= NOP_VAL;
    end else if (flush) begin
      main_q <= NOP_VAL;
    end else if (load_main) begin
      main_q <= main_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d   = ST_HALF;
            load_main = 1'b1;
          end
        end
        ST_HALF: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push && (SKID != 0)) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d   = ST_HALF;
            load_main = 1'b1;
            pop_skid  = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: SKID=1 and SKID=0 instances share stimulus and are
// checked every cycle against queue models, plus directed literal checks.
module tb_pipe_stage;

  localparam int W = 104;
  localparam logic [W-1:0] NOP = '0;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         in_valid, flush, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   occ1;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   occ0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] del0[$];
  logic [W-1:0] cv[4];
  bit           rdy = 1'b0;
  bit           ir1_m, ir0_m;

  always #5 clk_in = ~clk_in;

  pipe_stage #(.SKID(1)) dut1 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occ1)
  );

  pipe_stage #(.SKID(0)) dut0 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .occupancy (occ0)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Model: a FIFO of capacity 2 (skid) or 1 (no skid), emptied by reset/flush.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q1.delete();
      q0.delete();
      rdy = 1'b0;
    end else begin
      ir1_m = rdy && (q1.size() < 2);
      ir0_m = rdy && ((q0.size() == 0) || out_ready);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (in_valid && ir1_m) q1.push_back(in_data);
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (in_valid && ir0_m) q0.push_back(in_data);
      end
      rdy = 1'b1;
    end
  end

  always @(negedge clk_in) begin
    chk("in_ready_s1",  W'(in_ready1),  W'(rdy && (q1.size() < 2)));
    chk("out_valid_s1", W'(out_valid1), W'(q1.size() > 0));
    chk("out_data_s1",  out_data1,      (q1.size() > 0) ? q1[0] : NOP);
    chk("occ_s1",       W'(occ1),       W'(q1.size()));
    chk("in_ready_s0",  W'(in_ready0),  W'(rdy && ((q0.size() == 0) || out_ready)));
    chk("out_valid_s0", W'(out_valid0), W'(q0.size() > 0));
    chk("out_data_s0",  out_data0,      (q0.size() > 0) ? q0[0] : NOP);
    chk("occ_s0",       W'(occ0),       W'(q0.size()));
    if (!rst_in && !flush && out_valid0 && out_ready) del0.push_back(out_data0);
  end

  initial begin
    int  idx;
    bit  acc;
    logic [W-1:0] a1, a2, a3, b1;
    a1 = 104'hA1; a2 = 104'hA2; a3 = 104'hA3; b1 = 104'hB1;
    cv[0] = 104'hC1; cv[1] = 104'hC2; cv[2] = 104'hC3; cv[3] = 104'hC4;

    rst_in = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 104'h5A5A;
    #1;
    chk("rst_in_ready", W'(in_ready1), W'(0));
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    // first edge after reset: nothing accepted even with in_valid high
    chk("post_rst_ready", W'(in_ready1), W'(1));
    chk("post_rst_valid", W'(out_valid1), W'(0));

    in_data = a1; tick();
    chk("stream_a1", out_data1, a1);
    chk("stream_occ", W'(occ1), W'(1));
    in_data = a2; tick();
    chk("stream_a2", out_data1, a2);
    in_data = a3; tick();
    chk("stream_a3", out_data1, a3);
    chk("stream_occ3", W'(occ1), W'(1));
    in_valid = 1'b0; tick();
    tick();

    out_ready = 1'b0; in_valid = 1'b1; in_data = a1; tick();
    in_data = a2; tick();
    chk("full_ready", W'(in_ready1), W'(0));
    chk("full_occ", W'(occ1), W'(2));
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", out_data1, a1);
    end
    out_ready = 1'b1; tick();
    chk("pop_a2", out_data1, a2);
    chk("pop_ready", W'(in_ready1), W'(1));
    tick();
    chk("drained", W'(out_valid1), W'(0));
    tick();

    out_ready = 1'b0; in_valid = 1'b1; in_data = a1; tick();
    in_data = a2; tick();
    flush = 1'b1; in_data = b1; tick();
    chk("flush_valid", W'(out_valid1), W'(0));
    chk("flush_data", out_data1, NOP);
    chk("flush_occ", W'(occ1), W'(0));
    chk("flush_ready", W'(in_ready1), W'(1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_b1", W'(out_valid1), W'(0));
    end

    out_ready = 1'b0; in_valid = 1'b1; in_data = a1; tick();
    in_data = a2; tick();
    in_valid = 1'b0;
    chk("pre_rst_occ", W'(occ1), W'(2));
    #2 rst_in = 1'b1;
    #1;
    chk("async_valid", W'(out_valid1), W'(0));
    chk("async_data", out_data1, NOP);
    chk("async_occ", W'(occ1), W'(0));
    chk("async_data_s0", out_data0, NOP);
    tick(); tick();
    rst_in = 1'b0;
    tick();
    chk("rerst_ready", W'(in_ready1), W'(1));
    chk("rerst_valid", W'(out_valid1), W'(0));

    del0.delete();
    idx = 0;
    for (int c = 0; c < 40 && del0.size() < 4; c++) begin
      in_valid  = (idx < 4);
      in_data   = cv[(idx < 4) ? idx : 3];
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid0) chk("mirror_s0", W'(in_ready0), W'(out_ready));
      acc = in_valid && in_ready0;
      tick();
      if (acc) idx++;
    end
    chk("c_count", W'(del0.size()), W'(4));
    for (int k = 0; k < 4; k++)
      chk("c_order", (k < del0.size()) ? del0[k] : NOP, cv[k]);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom, $urandom, 8'($urandom)};
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 104, payload width in bits (ID->EX bundle: rdE, rdIdx, instIdx, instType, rs1Data, rs2Data).
REQ-002 Parameter NOP_VAL, default all-zero, payload driven while empty, flushed or in reset (encodes idNOP/typeNOP/writeDisable/regNOP).
REQ-003 Parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single register with combinational back-pressure.
REQ-004 clk_in  input  1  clock, all state on rising edge.
REQ-005 rst_in  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  upstream presents a beat.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 flush  input  1  discard all held beats (branch mispredict).
REQ-010 out_valid  output  1  out_data holds a live beat.
REQ-011 out_ready  input  1  downstream consumes this cycle; low = stall.
REQ-012 out_data  output  DATA_W  head payload; NOP_VAL when out_valid=0.
REQ-013 occupancy  output  2  live beats held (0..2; max 1 when SKID=0).

Function
- REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both evaluated on the same rising edge.
- REQ-015 SKID=1 states: EMPTY (occ 0), HALF (occ 1, main reg live), FULL (occ 2, main + skid live).
- REQ-016 EMPTY: in -> HALF, data to main reg; out_valid rises next cycle (latency 1).
- REQ-017 HALF: in & out -> HALF, main reg reloaded; in only -> FULL, data to skid; out only -> EMPTY; neither -> HALF.
- REQ-018 FULL: out -> HALF, skid moves to main; no in possible.
- REQ-019 SKID=1: in_ready = (state != FULL), registered-derived, no combinational path from out_ready.
- REQ-020 SKID=0: in_ready = ~out_valid | out_ready; states EMPTY/HALF only; sustained throughput 1 beat/cycle with out_ready high.
- REQ-021 Full throughput: with in_valid and out_ready held high, one beat per cycle, order preserved, no loss or duplication.
- REQ-022 Flush: next state EMPTY, out_valid=0, out_data=NOP_VAL, occupancy=0, regardless of in/out activity that cycle; a beat offered in the flush cycle is dropped.
- REQ-023 flush while out_ready=0 and FULL: both entries discarded; in_ready high the following cycle.
- REQ-024 out_data and out_valid are stable while out_valid=1 and out_ready=0 (stall hold).
- REQ-025 in_data is sampled only on a transfer in; payload bits pass unmodified.

Reset
- REQ-026 While rst_in=1: state EMPTY, out_valid=0, out_data=NOP_VAL, occupancy=0, skid reg=NOP_VAL, in_ready=0.
- REQ-027 First rising edge after rst_in falls: in_ready=1, no beat accepted on that edge if in_valid was sampled during reset.
- REQ-028 Reset mid-operation discards all held beats without producing out_valid.

Structure
- REQ-029 NOP_VAL components (idNOP, typeNOP, regNOP, ZERO32, writeDisable) and the state encoding come from the shared defines package; no literals in the module.
- REQ-030 One sub-module pipe_skid_buf (skid entry + mux) instantiated only when SKID=1; replaces ID_EX and future IF_ID/EX_MEM/MEM_WB registers.

Verification
- REQ-031 Reset, then in_valid=1 with data 0x..A1, A2, A3 consecutive, out_ready=1 -> out_data A1,A2,A3 on cycles 1,2,3, occupancy 1 throughout.
- REQ-032 HALF holding A1, out_ready=0, in A2 -> FULL, in_ready=0, out_data=A1 held 3 stall cycles; out_ready=1 -> A1 then A2, in_ready=1 after first pop.
- REQ-033 FULL, flush=1 with in_valid=1 data B1 -> next cycle out_valid=0, out_data=NOP_VAL, occupancy=0; B1 never appears.
- REQ-034 rst_in asserted asynchronously mid-cycle in FULL -> outputs NOP_VAL/0 immediately, before next clock edge.
- REQ-035 SKID=0, out_ready toggling 1,0,1,0 with continuous input C1..C4 -> in_ready mirrors out_ready when occupied, C1..C4 delivered in order.
- REQ-036 Random in_valid/out_ready/flush (1000 cycles) against scoreboard -> no loss, duplication or reordering between flushes.
